// File: rtl/alu_cmd_sequencer_if.sv
// rtl/alu_cmd_sequencer_if.sv - command, ALU and response channel bundle for alu_cmd_sequencer
interface alu_cmd_sequencer_if #(
  parameter int DW = 8
);
  // Command channel (upstream -> sequencer)
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_load;
  logic [2:0]    cmd_op;
  logic [1:0]    cmd_rd;
  logic [1:0]    cmd_ra;
  logic [1:0]    cmd_rb;
  logic [DW-1:0] cmd_imm;

  // Combinational ALU side
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [2:0]    alu_op;
  logic [DW-1:0] alu_out;

  // Response channel (sequencer -> consumer)
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [1:0]    rsp_rd;
  logic          rsp_err;

  // Sequencer view
  modport slave (
    input  cmd_valid, cmd_load, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_imm,
    output cmd_ready,
    output alu_a, alu_b, alu_op,
    input  alu_out,
    output rsp_valid, rsp_data, rsp_rd, rsp_err,
    input  rsp_ready
  );

  // Upstream issuer / ALU / consumer view
  modport master (
    output cmd_valid, cmd_load, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_imm,
    input  cmd_ready,
    input  alu_a, alu_b, alu_op,
    output alu_out,
    input  rsp_valid, rsp_data, rsp_rd, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - transaction-level command sequencer for the 8-bit combinational ALU
module alu_cmd_sequencer #(
  parameter int DW    = 8,
  parameter int NREGS = 4,
  parameter int CNTW  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  alu_cmd_sequencer_if.slave   bus,
  output logic [CNTW-1:0]      op_count_o,
  output logic                 busy_o
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

  logic [1:0]      state_q,    state_d;
  logic [DW-1:0]   regs_q [NREGS];
  logic [DW-1:0]   regs_d [NREGS];
  logic [1:0]      rd_q,       rd_d;
  logic [DW-1:0]   alu_a_q,    alu_a_d;
  logic [DW-1:0]   alu_b_q,    alu_b_d;
  logic [2:0]      alu_op_q,   alu_op_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;
  logic [1:0]      rsp_rd_q,   rsp_rd_d;
  logic            rsp_err_q,  rsp_err_d;
  logic [CNTW-1:0] op_count_q, op_count_d;

  // Next-state logic: one command in flight, walking IDLE -> (ISSUE -> CAPTURE ->) RESP -> IDLE
  always_comb begin
    state_d    = state_q;
    regs_d     = regs_q;
    rd_d       = rd_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    rsp_data_d = rsp_data_q;
    rsp_rd_d   = rsp_rd_q;
    rsp_err_d  = rsp_err_q;
    op_count_d = op_count_q;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          rd_d = bus.cmd_rd;
          if (bus.cmd_load) begin
            regs_d[bus.cmd_rd] = bus.cmd_imm;
            rsp_data_d         = bus.cmd_imm;
            rsp_rd_d           = bus.cmd_rd;
            rsp_err_d          = 1'b0;
            state_d            = S_RESP;
          end else begin
            // Operands are read here, so rd may alias ra/rb and still see old values
            alu_a_d  = regs_q[bus.cmd_ra];
            alu_b_d  = regs_q[bus.cmd_rb];
            alu_op_d = bus.cmd_op;
            state_d  = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        // Give the combinational ALU a full cycle with stable inputs
        state_d = S_CAPTURE;
      end

      S_CAPTURE: begin
        rsp_data_d = bus.alu_out;
        rsp_rd_d   = rd_q;
        if (alu_op_q[2:1] == 2'b11) begin
          rsp_err_d = 1'b1;
        end else begin
          regs_d[rd_q] = bus.alu_out;
          rsp_err_d    = 1'b0;
        end
        state_d = S_RESP;
      end

      S_RESP: begin
        if (bus.rsp_ready) begin
          if (op_count_q != {CNTW{1'b1}}) begin
            op_count_d = op_count_q + 1'b1;
          end
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset drops any in-flight command without a response
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      rd_q       <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      rsp_data_q <= '0;
      rsp_rd_q   <= '0;
      rsp_err_q  <= 1'b0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      regs_q     <= regs_d;
      rd_q       <= rd_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      rsp_data_q <= rsp_data_d;
      rsp_rd_q   <= rsp_rd_d;
      rsp_err_q  <= rsp_err_d;
      op_count_q <= op_count_d;
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_rd    = rsp_rd_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_op    = alu_op_q;
  assign op_count_o    = op_count_q;
  assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - directed scoreboard bench for alu_cmd_sequencer
module tb_alu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] op_count;
  logic        busy;

  alu_cmd_sequencer_if #(.DW(8)) bus ();

  alu_cmd_sequencer #(.DW(8), .NREGS(4), .CNTW(16)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .bus        (bus),
    .op_count_o (op_count),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  // Reference combinational ALU
  logic [15:0] rot_w;
  always_comb begin
    rot_w = {bus.alu_a, bus.alu_a} << bus.alu_b[2:0];
    case (bus.alu_op)
      3'b000:  bus.alu_out = bus.alu_a + bus.alu_b;
      3'b001:  bus.alu_out = bus.alu_a - bus.alu_b;
      3'b010:  bus.alu_out = rot_w[15:8];
      3'b011:  bus.alu_out = bus.alu_a ^ bus.alu_b;
      3'b100:  bus.alu_out = bus.alu_a & bus.alu_b;
      3'b101:  bus.alu_out = bus.alu_a | bus.alu_b;
      default: bus.alu_out = 8'hFF;
    endcase
  end

  typedef struct {
    logic [7:0] data;
    logic [1:0] rd;
    logic       err;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_rsp    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_cmd(input logic ld, input logic [2:0] op, input logic [1:0] rd,
                          input logic [1:0] ra, input logic [1:0] rb, input logic [7:0] imm,
                          input bit push, input logic [7:0] edata, input logic eerr, input int elat);
    exp_t e;
    int w = 0;
    while (!bus.cmd_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 50) check("cmd_ready_timeout", 32'd0, 32'd1);
    bus.cmd_load  = ld;
    bus.cmd_op    = op;
    bus.cmd_rd    = rd;
    bus.cmd_ra    = ra;
    bus.cmd_rb    = rb;
    bus.cmd_imm   = imm;
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    if (push) begin
      e.data = edata; e.rd = rd; e.err = eerr; e.lat = elat;
      sb.push_back(e);
    end
  endtask

  task automatic get_rsp(input string tag);
    exp_t e;
    int lat = 1;
    while (!bus.rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.rsp_valid) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    if (sb.size() == 0) begin
      check({tag, "_unexpected"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_data"}, {24'd0, bus.rsp_data}, {24'd0, e.data});
      check({tag, "_rd"},   {30'd0, bus.rsp_rd},   {30'd0, e.rd});
      check({tag, "_err"},  {31'd0, bus.rsp_err},  {31'd0, e.err});
      if (e.lat != 0) check({tag, "_lat"}, lat, e.lat);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_rsp++;
    check({tag, "_op_count"}, {16'd0, op_count}, n_rsp);
    check({tag, "_valid_drop"}, {31'd0, bus.rsp_valid}, 32'd0);
  endtask

  initial begin
    bit seen;
    bus.cmd_valid = 1'b0; bus.cmd_load = 1'b0; bus.cmd_op = 3'd0;
    bus.cmd_rd = 2'd0; bus.cmd_ra = 2'd0; bus.cmd_rb = 2'd0; bus.cmd_imm = 8'd0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_busy",      {31'd0, busy},          32'd0);
    check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_op_count",  {16'd0, op_count},      32'd0);
    check("rst_alu_a",     {24'd0, bus.alu_a},     32'd0);
    check("rst_alu_op",    {29'd0, bus.alu_op},    32'd0);
    check("rst_rsp_data",  {24'd0, bus.rsp_data},  32'd0);

    // Loads and add
    send_cmd(1, 3'd0, 2'd0, 2'd0, 2'd0, 8'h19, 1, 8'h19, 0, 1); get_rsp("ld_r0");
    send_cmd(1, 3'd0, 2'd1, 2'd0, 2'd0, 8'h1E, 1, 8'h1E, 0, 1); get_rsp("ld_r1");
    send_cmd(0, 3'd0, 2'd2, 2'd0, 2'd1, 8'h00, 1, 8'h37, 0, 3); get_rsp("add");

    // Subtract both directions, second one wraps
    send_cmd(0, 3'd1, 2'd3, 2'd1, 2'd0, 8'h00, 1, 8'h05, 0, 3); get_rsp("sub");
    send_cmd(0, 3'd1, 2'd3, 2'd0, 2'd1, 8'h00, 1, 8'hFB, 0, 3); get_rsp("sub_wrap");
    check("hold_alu_op", {29'd0, bus.alu_op}, 32'd1);
    check("hold_alu_a",  {24'd0, bus.alu_a},  32'h19);
    check("hold_alu_b",  {24'd0, bus.alu_b},  32'h1E);

    // Rotate, xor, and, or
    send_cmd(1, 3'd0, 2'd0, 2'd0, 2'd0, 8'h0A, 1, 8'h0A, 0, 1); get_rsp("ld_r0b");
    send_cmd(1, 3'd0, 2'd1, 2'd0, 2'd0, 8'h05, 1, 8'h05, 0, 1); get_rsp("ld_r1b");
    send_cmd(0, 3'd2, 2'd2, 2'd0, 2'd1, 8'h00, 1, 8'h41, 0, 3); get_rsp("rol");
    send_cmd(1, 3'd0, 2'd0, 2'd0, 2'd0, 8'h0F, 1, 8'h0F, 0, 1); get_rsp("ld_r0c");
    send_cmd(1, 3'd0, 2'd1, 2'd0, 2'd0, 8'h03, 1, 8'h03, 0, 1); get_rsp("ld_r1c");
    send_cmd(0, 3'd3, 2'd2, 2'd0, 2'd1, 8'h00, 1, 8'h0C, 0, 3); get_rsp("xor");
    send_cmd(0, 3'd4, 2'd3, 2'd0, 2'd1, 8'h00, 1, 8'h03, 0, 3); get_rsp("and");
    send_cmd(1, 3'd0, 2'd1, 2'd0, 2'd0, 8'h05, 1, 8'h05, 0, 1); get_rsp("ld_r1d");
    send_cmd(0, 3'd5, 2'd3, 2'd2, 2'd1, 8'h00, 1, 8'h0D, 0, 3); get_rsp("or");

    // Undefined opcode must not write its destination
    send_cmd(1, 3'd0, 2'd3, 2'd0, 2'd0, 8'h55, 1, 8'h55, 0, 1); get_rsp("ld_r3");
    send_cmd(0, 3'd6, 2'd3, 2'd0, 2'd1, 8'h00, 1, 8'hFF, 1, 3); get_rsp("undef");
    send_cmd(1, 3'd0, 2'd0, 2'd0, 2'd0, 8'h00, 1, 8'h00, 0, 1); get_rsp("ld_zero");
    send_cmd(0, 3'd0, 2'd2, 2'd3, 2'd0, 8'h00, 1, 8'h55, 0, 3); get_rsp("r3_readback");

    // Back-pressure: response held stable, command pulse ignored
    bus.rsp_ready = 1'b0;
    send_cmd(1, 3'd0, 2'd1, 2'd0, 2'd0, 8'h77, 1, 8'h77, 0, 0);
    for (int c = 0; c < 5; c++) begin
      check("stall_valid",     {31'd0, bus.rsp_valid}, 32'd1);
      check("stall_data",      {24'd0, bus.rsp_data},  32'h77);
      check("stall_rd",        {30'd0, bus.rsp_rd},    32'd1);
      check("stall_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
      if (c == 2) begin
        bus.cmd_load = 1'b1; bus.cmd_rd = 2'd2; bus.cmd_imm = 8'hEE; bus.cmd_valid = 1'b1;
      end
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
    end
    get_rsp("stall_rsp");
    send_cmd(0, 3'd0, 2'd3, 2'd2, 2'd0, 8'h00, 1, 8'h55, 0, 3); get_rsp("r2_unchanged");

    // Reset during ISSUE drops the command
    send_cmd(1, 3'd0, 2'd1, 2'd0, 2'd0, 8'h12, 1, 8'h12, 0, 1); get_rsp("ld_pre_rst");
    send_cmd(0, 3'd0, 2'd0, 2'd1, 2'd1, 8'h00, 0, 8'h00, 0, 0);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_rsp = 0;
    check("mid_rst_busy",      {31'd0, busy},          32'd0);
    check("mid_rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("mid_rst_op_count",  {16'd0, op_count},      32'd0);
    check("mid_rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("mid_rst_alu_a",     {24'd0, bus.alu_a},     32'd0);
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (bus.rsp_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("mid_rst_no_rsp", {31'd0, seen}, 32'd0);
    send_cmd(0, 3'd0, 2'd0, 2'd1, 2'd2, 8'h00, 1, 8'h00, 0, 3); get_rsp("rst_r1_r2");
    send_cmd(0, 3'd5, 2'd0, 2'd3, 2'd1, 8'h00, 1, 8'h00, 0, 3); get_rsp("rst_r3");
    check("sb_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
